result_unloader: RTL and testbench
==================================

RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 Parameter N_ROWS, default 4, result matrix row count (6x6 input, 3x3 kernel).
REQ-002 Parameter N_COLS, default 4, result matrix column count.
REQ-003 Parameter DW, default 8, result element width in bits.
REQ-004 Parameter AUTO_DIV, default 16, clock cycles per element in auto mode; minimum 2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 res_valid  input  1  convLayer result matrix available on res_data.
REQ-008 res_data  input  N_ROWS*N_COLS*DW  flattened result, element (r,c) at bits [(r*N_COLS+c)*DW +: DW].
REQ-009 res_ready  output  1  high when the block will accept a new matrix.
REQ-010 step  input  1  level switch; each 0->1 transition advances one element in manual mode.
REQ-011 auto_mode  input  1  1 = advance every AUTO_DIV cycles; 0 = manual step.
REQ-012 data_out  output  DW  element currently presented.
REQ-013 out_row  output  clog2(N_ROWS)  row index of data_out.
REQ-014 out_col  output  clog2(N_COLS)  column index of data_out.
REQ-015 out_valid  output  1  data_out/out_row/out_col are meaningful.
REQ-016 done  output  1  single-cycle pulse after the last element's display interval ends.

Function
REQ-017 FSM states IDLE, SHOW, DONE; exactly one active at any time.
REQ-018 IDLE: res_ready=1, out_valid=0; res_valid=1 captures all of res_data into an internal buffer in that cycle and moves to SHOW with index (0,0).
REQ-019 Capture handshake is res_valid AND res_ready; res_valid in SHOW or DONE is ignored and the buffer is not modified.
REQ-020 SHOW: res_ready=0, out_valid=1, data_out = buffer element at (out_row,out_col), registered, valid from the cycle after capture.
REQ-021 Step edge detection: step registered once; advance event = step AND NOT step_q; the level held high yields exactly one advance.
REQ-022 step_q SHALL update in every state, so a step held high across capture causes no advance.
REQ-023 Auto mode: cycle counter counts 0..AUTO_DIV-1 in SHOW; advance event on count AUTO_DIV-1, then counter wraps to 0.
REQ-024 Counter clears on capture and on any change of auto_mode; step edges are ignored while auto_mode=1.
REQ-025 Advance order row-major: out_col increments; at N_COLS-1 it wraps to 0 and out_row increments.
REQ-026 Advance at (N_ROWS-1,N_COLS-1) moves to DONE; out_row/out_col do not wrap to (0,0) in SHOW.
REQ-027 DONE lasts exactly one cycle: done=1, out_valid=0, res_ready=0, then IDLE.
REQ-028 Indices hold value outside SHOW; data_out holds last presented element in DONE/IDLE.
REQ-029 Buffer contents persist until the next capture; no arithmetic on element values.
REQ-030 Manual step rate unbounded; auto advance rate exactly one per AUTO_DIV cycles.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, out_row=0, out_col=0, data_out=0, out_valid=0, done=0, res_ready=1 from the following cycle.
REQ-032 rst=1 clears step_q to 0 and the auto counter to 0; the buffer need not be cleared.
REQ-033 rst mid-SHOW aborts readout with no done pulse; a res_valid in the cycle after reset release is accepted.
REQ-034 rst has priority over res_valid, step and auto advance in the same cycle.

Verification
REQ-035 Manual: capture matrix elements = 8'h10+index, pulse step 16 times -> data_out 8'h10..8'h1F in row-major order, indices matching, done pulse once, then res_ready=1.
REQ-036 Held step: step high across capture and 40 cycles -> data_out stays 8'h10 at (0,0); one 0->1 later -> (0,1).
REQ-037 Auto: auto_mode=1, AUTO_DIV=16 -> each element valid exactly 16 cycles; done 256 cycles after first out_valid.
REQ-038 Back-pressure: second res_valid with different data during SHOW -> ignored, remaining elements from first matrix.
REQ-039 Reset mid-readout at element (2,1) -> next cycle out_valid=0, indices (0,0), res_ready=1, no done.
REQ-040 Wrap: advance from (0,3) -> (1,0); advance from (3,3) -> DONE for one cycle, then IDLE.

Source files
------------

// File: rtl/result_unloader.sv
// Holds one convLayer result matrix and presents it element by element in row-major
// order, advanced by manual step edges or by a fixed auto-mode interval.
module result_unloader #(
    parameter int N_ROWS   = 4,
    parameter int N_COLS   = 4,
    parameter int DW       = 8,
    parameter int AUTO_DIV = 16,
    localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int CLW     = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_valid,
    input  logic [N_ROWS*N_COLS*DW-1:0] res_data,
    output logic                        res_ready,
    input  logic                        step,
    input  logic                        auto_mode,
    output logic [DW-1:0]               data_out,
    output logic [RW-1:0]               out_row,
    output logic [CLW-1:0]              out_col,
    output logic                        out_valid,
    output logic                        done
);

    localparam int NE = N_ROWS * N_COLS;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int CW = $clog2(AUTO_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic [NE*DW-1:0]      r_buf;
    logic                  r_step_q;
    logic                  r_auto_q;
    logic [CW-1:0]         r_cnt;
    logic [RW-1:0]         r_row;
    logic [CLW-1:0]        r_col;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_data;

    logic                  w_capture;
    logic                  w_step_edge;
    logic                  w_auto_tick;
    logic                  w_auto_chg;
    logic                  w_adv;
    logic                  w_last;
    logic [IW-1:0]         w_idx_n;

    // Ready is only ever asserted in IDLE, so the handshake reduces to IDLE && res_valid.
    assign w_capture   = !rst && (r_state == IDLE) && res_valid;
    assign w_step_edge = step && !r_step_q;
    assign w_auto_chg  = auto_mode ^ r_auto_q;
    assign w_auto_tick = (r_cnt == CW'(AUTO_DIV - 1));
    assign w_adv       = (r_state == SHOW) && (auto_mode ? w_auto_tick : w_step_edge);
    assign w_last      = (r_row == RW'(N_ROWS - 1)) && (r_col == CLW'(N_COLS - 1));
    assign w_idx_n     = r_idx + 1'b1;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (res_valid) w_state_n = SHOW;
            SHOW:    if (w_adv && w_last) w_state_n = DONE;
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // The step history tracks the pin in every state so a level held across capture never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
        r_auto_q <= auto_mode;
    end

    always_ff @(posedge clk) begin
        if (rst || w_capture || w_auto_chg) begin
            r_cnt <= '0;
        end else if ((r_state == SHOW) && auto_mode) begin
            r_cnt <= w_auto_tick ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= res_data;
        end
    end

    // The final advance leaves indices and data untouched so they hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_idx  <= '0;
            r_data <= '0;
        end else if (w_capture) begin
            r_row  <= '0;
            r_col  <= '0;
            r_idx  <= '0;
            r_data <= res_data[DW-1:0];
        end else if (w_adv && !w_last) begin
            r_idx  <= w_idx_n;
            r_data <= r_buf[int'(w_idx_n)*DW +: DW];
            if (r_col == CLW'(N_COLS - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign res_ready = (r_state == IDLE);
    assign out_valid = (r_state == SHOW);
    assign done      = (r_state == DONE);
    assign data_out  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;

endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench for result_unloader: expected element sequences are queued at capture
// and a negedge monitor matches every presented element and done pulse against them.
module tb_result_unloader;

    localparam int N_ROWS   = 4;
    localparam int N_COLS   = 4;
    localparam int DW       = 8;
    localparam int AUTO_DIV = 16;
    localparam int NE       = N_ROWS * N_COLS;
    localparam int TOT      = NE * DW;
    localparam int RW       = $clog2(N_ROWS);
    localparam int CLW      = $clog2(N_COLS);

    logic            clk = 1'b0;
    logic            rst;
    logic            res_valid;
    logic [TOT-1:0]  res_data;
    logic            res_ready;
    logic            step;
    logic            auto_mode;
    logic [DW-1:0]   data_out;
    logic [RW-1:0]   out_row;
    logic [CLW-1:0]  out_col;
    logic            out_valid;
    logic            done;

    always #5 clk = ~clk;

    result_unloader #(
        .N_ROWS(N_ROWS), .N_COLS(N_COLS), .DW(DW), .AUTO_DIV(AUTO_DIV)
    ) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .step(step), .auto_mode(auto_mode),
        .data_out(data_out), .out_row(out_row), .out_col(out_col),
        .out_valid(out_valid), .done(done)
    );

    typedef struct {
        bit is_done;
        int row;
        int col;
        int data;
        int len;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int elem(input logic [TOT-1:0] m, input int i);
        return int'(m[i*DW +: DW]);
    endfunction

    function automatic logic [TOT-1:0] rand_mat();
        logic [TOT-1:0] m;
        for (int i = 0; i < NE; i++) m[i*DW +: DW] = DW'($urandom);
        return m;
    endfunction

    // Reference: a captured matrix is shown in row-major order, optionally followed by done.
    task automatic push_mat(input logic [TOT-1:0] m, input int n, input bit with_done, input int len);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e.is_done = 1'b0;
            e.row     = i / N_COLS;
            e.col     = i % N_COLS;
            e.data    = elem(m, i);
            e.len     = len;
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.row = 0; e.col = 0; e.data = 0; e.len = 0;
            exp_q.push_back(e);
        end
    endtask

    bit pv = 1'b0;
    int pr = 0, pc = 0, run = 0, cur_len = 0, cur_data = 0;

    always @(negedge clk) begin
        ev_t e;
        bit  newel;
        newel = out_valid && (!pv || int'(out_row) != pr || int'(out_col) != pc);
        if (pv && cur_len != 0 && (newel || !out_valid)) chk("elem_len", run, cur_len);
        if (newel) begin
            run = 1;
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_elem: got (%0d,%0d)=%0h, required none", out_row, out_col, data_out);
                cur_len = 0; cur_data = int'(data_out);
            end else begin
                e = exp_q.pop_front();
                chk("elem_kind", 0, e.is_done);
                chk("elem_row", out_row, e.row);
                chk("elem_col", out_col, e.col);
                chk("elem_data", data_out, e.data);
                cur_len = e.len; cur_data = e.data;
            end
        end else if (out_valid) begin
            run++;
            chk("data_stable", data_out, cur_data);
        end
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_done: got done=1, required 0 (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", 1, e.is_done);
                chk("done_ovalid", out_valid, 0);
                chk("done_ready", res_ready, 0);
            end
        end
        pv = out_valid; pr = int'(out_row); pc = int'(out_col);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic capture(input logic [TOT-1:0] m);
        chk("ready_before_cap", res_ready, 1);
        res_data = m; res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic pulse();
        step = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        step = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic check_idle_after(input int last_data);
        @(negedge clk);
        chk("ready_after", res_ready, 1);
        chk("ovalid_after", out_valid, 0);
        chk("row_hold", out_row, N_ROWS - 1);
        chk("col_hold", out_col, N_COLS - 1);
        chk("data_hold", data_out, last_data);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TOT-1:0] m, m2;
        int t0, t1;
        bit got;
        rst = 1'b1; res_valid = 1'b0; res_data = '0; step = 1'b0; auto_mode = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", res_ready, 1);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data_out, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        tick();

        // Manual readout of 0x10+index
        for (int i = 0; i < NE; i++) m[i*DW +: DW] = DW'(8'h10 + i);
        push_mat(m, NE, 1'b1, 0);
        capture(m);
        repeat (NE) pulse();
        check_idle_after(8'h1F);

        // Second res_valid during SHOW is ignored
        m = rand_mat(); m2 = ~m;
        push_mat(m, NE, 1'b1, 0);
        capture(m);
        repeat (3) pulse();
        res_data = m2; res_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("bp_ready_low", res_ready, 0);
        end
        res_valid = 1'b0;
        repeat (NE - 3) pulse();
        check_idle_after(elem(m, NE - 1));

        // Step held high across capture gives no advance
        for (int i = 0; i < NE; i++) m[i*DW +: DW] = DW'(8'h10 + i);
        push_mat(m, NE, 1'b1, 0);
        step = 1'b1;
        tick();
        capture(m);
        repeat (40) tick();
        @(negedge clk);
        chk("held_valid", out_valid, 1);
        chk("held_row", out_row, 0);
        chk("held_col", out_col, 0);
        chk("held_data", data_out, 8'h10);
        step = 1'b0; tick();
        step = 1'b1; tick();
        @(negedge clk);
        chk("held_next_row", out_row, 0);
        chk("held_next_col", out_col, 1);
        chk("held_next_data", data_out, 8'h11);
        step = 1'b0; tick();
        repeat (NE - 1) pulse();
        check_idle_after(8'h1F);

        // Auto mode with random step noise
        auto_mode = 1'b1; tick();
        m = rand_mat();
        push_mat(m, NE, 1'b1, AUTO_DIV);
        capture(m);
        t0 = cyc; got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
            step = 1'($urandom_range(0, 1));
        end
        t1 = cyc;
        chk("auto_done_seen", got, 1);
        chk("auto_done_lat", t1 - t0, NE * AUTO_DIV);
        step = 1'b0;
        tick();
        auto_mode = 1'b0;
        tick();

        // Reset at element (2,1), then capture right after release
        m = rand_mat();
        push_mat(m, 2 * N_COLS + 2, 1'b0, 0);
        capture(m);
        repeat (2 * N_COLS + 1) pulse();
        @(negedge clk);
        chk("pre_rst_row", out_row, 2);
        chk("pre_rst_col", out_col, 1);
        chk("pre_rst_data", data_out, elem(m, 2 * N_COLS + 1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m2 = rand_mat();
        res_data = m2; res_valid = 1'b1;
        @(negedge clk);
        chk("abort_ovalid", out_valid, 0);
        chk("abort_row", out_row, 0);
        chk("abort_col", out_col, 0);
        chk("abort_ready", res_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_data", data_out, 0);
        chk("abort_queue", exp_q.size(), 0);
        push_mat(m2, NE, 1'b1, 0);
        tick();
        res_valid = 1'b0;
        repeat (NE) pulse();
        check_idle_after(elem(m2, NE - 1));

        // Random transactions
        for (int k = 0; k < 3; k++) begin
            m = rand_mat();
            push_mat(m, NE, 1'b1, 0);
            repeat ($urandom_range(0, 3)) tick();
            capture(m);
            repeat (NE) pulse();
            check_idle_after(elem(m, NE - 1));
        end

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
